bus_transfer_sequencer: RTL and testbench
=========================================

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 The block SHALL have parameter NREG, default 8, meaning the number of register32_en_tri-style registers sharing one 32-bit tri-state bus.
REQ-002 The block SHALL have parameter IDX_W, default 3, meaning the width of the register index fields, with 2^IDX_W >= NREG.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid  input  1  transfer request present.
REQ-006 The block SHALL have port cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-007 The block SHALL have port cmd_src  input  IDX_W  index of the register driving the bus.
REQ-008 The block SHALL have port cmd_dst  input  IDX_W  index of the register latching from the bus.
REQ-009 The block SHALL have port eno  output  NREG  per-register output enables; all-zero or one-hot.
REQ-010 The block SHALL have port eni  output  NREG  per-register input (load) enables; all-zero or one-hot.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on transfer completion.
REQ-013 The block SHALL have port err  output  1  one-cycle pulse on a rejected command.
REQ-014 The block SHALL have port xfer_count  output  16  count of completed transfers.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DRIVE, LATCH and TURN.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-017 An accepted command with cmd_src==cmd_dst, cmd_src>=NREG or cmd_dst>=NREG SHALL be rejected: state stays IDLE, err=1 for the next cycle only, no eno/eni activity, xfer_count unchanged.
REQ-018 An accepted valid command SHALL capture src/dst internally and move to DRIVE; later changes on cmd_src/cmd_dst SHALL have no effect on the transfer in flight.
REQ-019 In DRIVE, eno[src]=1 and eni=0 (bus settle cycle); the next state SHALL be LATCH.
REQ-020 In LATCH, eno[src]=1 and eni[dst]=1, so the destination captures at the edge ending LATCH; xfer_count SHALL increment at that edge; the next state SHALL be TURN.
REQ-021 In TURN, eno=0, eni=0 and done=1 (bus turnaround); the next state SHALL be IDLE.
REQ-022 Latency: command accepted at edge T gives DRIVE in cycle T+1, LATCH in T+2, TURN/done in T+3, and cmd_ready=1 again in T+4; the maximum throughput SHALL be one transfer per 4 cycles.
REQ-023 eno, eni, busy, done and err SHALL be registered or decoded purely from registered state, with no combinational path from cmd_* to eno/eni.
REQ-024 At most one eno bit and at most one eni bit SHALL be high in any cycle; eno SHALL never change directly from one non-zero value to a different non-zero value.
REQ-025 xfer_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-026 cmd_valid held high continuously SHALL cause back-to-back transfers separated by TURN, with each command accepted exactly once.

Reset
REQ-027 When reset=1 at a rising edge, the next cycle SHALL have state=IDLE, eno=0, eni=0, busy=0, done=0, err=0, xfer_count=0 and cmd_ready=1.
REQ-028 Reset SHALL take priority over a simultaneous command acceptance, and the command SHALL be discarded.
REQ-029 Reset during DRIVE or LATCH SHALL abandon the transfer: no eni pulse after the reset edge, no done pulse, and no count increment.

Verification
REQ-030 The bench SHALL check: reset, then src=2, dst=5 -> eno=8'h04 for 2 cycles, eni=8'h20 in the second cycle only, done pulse in cycle T+3, xfer_count=1, cmd_ready high at T+4.
REQ-031 The bench SHALL check: src=3, dst=3 -> err pulse for 1 cycle, eno=eni=0 throughout, xfer_count unchanged, cmd_ready stays 1.
REQ-032 The bench SHALL check: cmd_valid held high with commands (0->1), (1->7), (7->0) -> three transfers 4 cycles apart, each with an all-zero eno cycle between them, and xfer_count=3.
REQ-033 The bench SHALL check: reset asserted in the DRIVE cycle of 4->6 -> eni[6] never asserted, no done pulse, and all outputs at their reset values the next cycle.
REQ-034 The bench SHALL check: cmd_src/cmd_dst changed during DRIVE -> the transfer still uses the originally captured indices.
REQ-035 The bench SHALL check: xfer_count preloaded to 16'hFFFF (via 65535 transfers or a forced value) plus one transfer -> xfer_count=16'h0000.

Source files
------------

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register moves over one shared 32-bit tri-state bus.
// Latency: accept at edge T -> DRIVE T+1, LATCH T+2, TURN/done T+3, ready again T+4.
// Backpressure: cmd_ready is high only in IDLE; a command transfers when cmd_valid && cmd_ready.
module bus_transfer_sequencer #(
    parameter int NREG  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IDX_W-1:0] cmd_src,
    input  logic [IDX_W-1:0] cmd_dst,
    output logic [NREG-1:0]  eno,
    output logic [NREG-1:0]  eni,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      xfer_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] src_q, dst_q;
    logic             err_q, err_d;
    logic [15:0]      count_q;
    logic             accept, cmd_ok;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        logic [31:0] wide;
        wide = 32'(idx);
        return wide < 32'(NREG);
    endfunction

    assign accept = cmd_valid && (state_q == IDLE);
    assign cmd_ok = (cmd_src != cmd_dst) && idx_in_range(cmd_src) && idx_in_range(cmd_dst);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_ok) state_d = DRIVE;
                    else        err_d   = 1'b1;
                end
            end
            DRIVE:   state_d = LATCH;
            LATCH:   state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept && cmd_ok) begin
                src_q <= cmd_src;
                dst_q <= cmd_dst;
            end
        end
    end

    // Counter only moves at the edge that ends LATCH, i.e. when the destination captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else if (state_q == LATCH) begin
            count_q <= count_q + 16'h0001;
        end
    end

    // Enables decode only from registered state and captured indices, never from cmd_*.
    always_comb begin
        eno = '0;
        eni = '0;
        for (int i = 0; i < NREG; i++) begin
            eno[i] = ((state_q == DRIVE) || (state_q == LATCH)) && (src_q == IDX_W'(i));
            eni[i] = (state_q == LATCH) && (dst_q == IDX_W'(i));
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == TURN);
    assign err        = err_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_bus_transfer_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_src;
    logic [2:0]  cmd_dst;
    logic [7:0]  eno;
    logic [7:0]  eni;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    bus_transfer_sequencer #(.NREG(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .eno        (eno),
        .eni        (eni),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        // reset together with a valid command: the command must be discarded
        reset = 1'b1; cmd_valid = 1'b1; cmd_src = 3'd0; cmd_dst = 3'd1;
        tick();
        checks++;
        if ({eno, eni, busy, done, err, cmd_ready, xfer_count} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state eno=%h eni=%h busy=%b done=%b err=%b rdy=%b cnt=%h required 00 00 0 0 0 1 0000",
                     eno, eni, busy, done, err, cmd_ready, xfer_count);
        end
        reset = 1'b0; cmd_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || eno !== 8'h00) begin
            errors++;
            $display("FAIL reset_discard busy=%b eno=%h required 0 00", busy, eno);
        end
    endtask

    task automatic test_transfer();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ready_before got %b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_src = 3'd2; cmd_dst = 3'd5;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (eno !== 8'h04 || eni !== 8'h00 || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL xfer_drive eno=%h eni=%h busy=%b rdy=%b done=%b required 04 00 1 0 0", eno, eni, busy, cmd_ready, done);
        end
        tick();
        checks++;
        if (eno !== 8'h04 || eni !== 8'h20 || done !== 1'b0) begin
            errors++;
            $display("FAIL xfer_latch eno=%h eni=%h done=%b required 04 20 0", eno, eni, done);
        end
        tick();
        checks++;
        if (eno !== 8'h00 || eni !== 8'h00 || done !== 1'b1 || xfer_count !== 16'd1) begin
            errors++;
            $display("FAIL xfer_turn eno=%h eni=%h done=%b cnt=%0d required 00 00 1 1", eno, eni, done, xfer_count);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || xfer_count !== 16'd1) begin
            errors++;
            $display("FAIL xfer_idle rdy=%b done=%b busy=%b cnt=%0d required 1 0 0 1", cmd_ready, done, busy, xfer_count);
        end
    endtask

    task automatic test_reject();
        cmd_valid = 1'b1; cmd_src = 3'd3; cmd_dst = 3'd3;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || eno !== 8'h00 || eni !== 8'h00 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse err=%b eno=%h eni=%h rdy=%b busy=%b required 1 00 00 1 0", err, eno, eni, cmd_ready, busy);
        end
        tick();
        checks++;
        if (err !== 1'b0 || eno !== 8'h00 || eni !== 8'h00 || xfer_count !== 16'd1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reject_after err=%b eno=%h eni=%h cnt=%0d rdy=%b required 0 00 00 1 1", err, eno, eni, xfer_count, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] srcs [3];
        logic [2:0] dsts [3];
        logic [7:0] exp_eno, exp_eni;
        srcs[0] = 3'd0; dsts[0] = 3'd1;
        srcs[1] = 3'd1; dsts[1] = 3'd7;
        srcs[2] = 3'd7; dsts[2] = 3'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmd_valid = 1'b1; cmd_src = srcs[0]; cmd_dst = dsts[0];
        for (int k = 0; k < 3; k++) begin
            exp_eno = 8'h01 << srcs[k];
            exp_eni = 8'h01 << dsts[k];
            tick();
            checks++;
            if (eno !== exp_eno || eni !== 8'h00) begin
                errors++;
                $display("FAIL b2b_drive%0d eno=%h eni=%h required %h 00", k, eno, eni, exp_eno);
            end
            if (k < 2) begin
                cmd_src = srcs[k+1]; cmd_dst = dsts[k+1];
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            checks++;
            if (eno !== exp_eno || eni !== exp_eni) begin
                errors++;
                $display("FAIL b2b_latch%0d eno=%h eni=%h required %h %h", k, eno, eni, exp_eno, exp_eni);
            end
            tick();
            checks++;
            if (eno !== 8'h00 || eni !== 8'h00 || done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_turn%0d eno=%h eni=%h done=%b required 00 00 1", k, eno, eni, done);
            end
            tick();
            checks++;
            if (cmd_ready !== 1'b1 || eno !== 8'h00) begin
                errors++;
                $display("FAIL b2b_idle%0d rdy=%b eno=%h required 1 00", k, cmd_ready, eno);
            end
        end
        tick();
        checks++;
        if (xfer_count !== 16'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count cnt=%0d busy=%b required 3 0", xfer_count, busy);
        end
    endtask

    task automatic test_reset_in_drive();
        cmd_valid = 1'b1; cmd_src = 3'd4; cmd_dst = 3'd6;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (eno !== 8'h10) begin
            errors++;
            $display("FAIL abort_drive eno=%h required 10", eno);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({eno, eni, busy, done, err, cmd_ready, xfer_count} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL abort_reset eno=%h eni=%h busy=%b done=%b err=%b rdy=%b cnt=%h required 00 00 0 0 0 1 0000",
                     eno, eni, busy, done, err, cmd_ready, xfer_count);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (eni[6] !== 1'b0 || done !== 1'b0 || xfer_count !== 16'd0) begin
                errors++;
                $display("FAIL abort_after%0d eni=%h done=%b cnt=%0d required 00 0 0", c, eni, done, xfer_count);
            end
        end
    endtask

    task automatic test_capture();
        cmd_valid = 1'b1; cmd_src = 3'd1; cmd_dst = 3'd2;
        tick();
        cmd_valid = 1'b0; cmd_src = 3'd6; cmd_dst = 3'd0;
        checks++;
        if (eno !== 8'h02) begin
            errors++;
            $display("FAIL capture_drive eno=%h required 02", eno);
        end
        tick();
        checks++;
        if (eno !== 8'h02 || eni !== 8'h04) begin
            errors++;
            $display("FAIL capture_latch eno=%h eni=%h required 02 04", eno, eni);
        end
        tick();
        tick();
        checks++;
        if (xfer_count !== 16'd1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL capture_count cnt=%0d rdy=%b required 1 1", xfer_count, cmd_ready);
        end
    endtask

    task automatic test_wrap();
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        tick();
        checks++;
        if (xfer_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload cnt=%h required ffff", xfer_count);
        end
        cmd_valid = 1'b1; cmd_src = 3'd5; cmd_dst = 3'd7;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (xfer_count !== 16'h0000 || done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count cnt=%h done=%b required 0000 1", xfer_count, done);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
        test_reset();
        test_transfer();
        test_reject();
        test_back_to_back();
        test_reset_in_drive();
        test_capture();
        test_wrap();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
